dma_copy_engine: RTL and testbench

//  Datapath/control core downstream of the AXI-Lite register block; consumes start, irq_enable, src_addr,
//  dst_addr and length, and returns busy and done to the status register.

---
 rtl/dma_copy_engine_if.sv | 46 ++++
 rtl/dma_copy_engine.sv | 192 +++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_engine_if.sv
// -----------------------------------------------------------------------------
// dma_copy_engine_if
//   Memory-side bus of the DMA copy engine: a read channel (request plus
//   returned data/response) and a write channel (request plus response).
//
//   Handshake rules: a request transfers on a cycle where valid && ready
//   are both high at the rising clock edge. Once valid is raised, the
//   address (and write data) stay stable until that transfer. valid does
//   not wait on ready. rd_dvalid and wr_bvalid are single-cycle strobes
//   with no ready; the engine always accepts them.
//
//   Modports:
//     master : engine side (drives requests, receives data/responses)
//     slave  : memory side (drives ready, data and responses)
// -----------------------------------------------------------------------------
interface dma_copy_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_dvalid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  wr_bvalid;
  logic [1:0]            wr_resp;

  modport master (
    output rd_addr, rd_valid,
    input  rd_ready, rd_dvalid, rd_data, rd_resp,
    output wr_addr, wr_data, wr_valid,
    input  wr_ready, wr_bvalid, wr_resp
  );

  modport slave (
    input  rd_addr, rd_valid,
    output rd_ready, rd_dvalid, rd_data, rd_resp,
    input  wr_addr, wr_data, wr_valid,
    output wr_ready, wr_bvalid, wr_resp
  );
endinterface

// File: rtl/dma_copy_engine.sv
// -----------------------------------------------------------------------------
// dma_copy_engine
//   Copies length bytes from src_addr to dst_addr one word at a time. Each
//   word is a read request, a wait for read data, a write request and a
//   wait for the write response. Completion sets a sticky done flag and
//   optionally pulses irq for one cycle.
//
//   Optional feature macro: DMA_ERR_CHECK_EN
//     defined   : a non-OKAY rd_resp/wr_resp aborts the transfer and sets
//                 the sticky error flag (done and irq still follow).
//     undefined : responses are ignored and error stays 0.
//
//   Ports:
//     ACLK, ARESET          clock, synchronous active-high reset
//     start                 launch pulse, honoured only when idle
//     irq_enable            irq enable, sampled at accepted start
//     src_addr, dst_addr    byte addresses, sampled at accepted start
//     length                byte count, sampled at accepted start
//     busy, done, irq       status (done sticky, irq one-cycle pulse)
//     error                 sticky error flag
//     dbg_state             current FSM state encoding
//     mem                   memory bus (master side)
//
//   Timing with zero-wait memory: 4 cycles per word; done becomes visible
//   4*words+2 cycles after the cycle in which start is high. The FINISH
//   state's actions are registered, so done/irq appear in the cycle after
//   FINISH.
// -----------------------------------------------------------------------------
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  irq_enable,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic                  error,
  output logic [2:0]            dbg_state,
  dma_copy_engine_if.master     mem
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BPW);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  words_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  irq_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  irq_q;
  logic                  error_q;
  logic                  rd_valid_q;
  logic                  wr_valid_q;
  logic [LEN_WIDTH-1:0]  start_words;
  logic                  rd_err;
  logic                  wr_err;

  // Low byte bits of length are dropped: partial words are not copied.
  assign start_words = length >> SHIFT;

`ifdef DMA_ERR_CHECK_EN
  assign rd_err = (mem.rd_resp != 2'b00);
  assign wr_err = (mem.wr_resp != 2'b00);
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
  logic unused_resp;
  assign unused_resp = ^{mem.rd_resp, mem.wr_resp};
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      words_q    <= '0;
      data_q     <= '0;
      irq_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            words_q  <= start_words;
            irq_en_q <= irq_enable;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (start_words == '0) begin
              state <= FINISH;
            end else begin
              state      <= RD_REQ;
              rd_valid_q <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (mem.rd_ready) begin
            rd_valid_q <= 1'b0;
            state      <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem.rd_dvalid) begin
            if (rd_err) begin
              // Failing word is dropped; no write is issued for it.
              error_q <= 1'b1;
              state   <= FINISH;
            end else begin
              data_q     <= mem.rd_data;
              wr_valid_q <= 1'b1;
              state      <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem.wr_ready) begin
            wr_valid_q <= 1'b0;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (mem.wr_bvalid) begin
            if (wr_err) begin
              // Failing word is not counted and addresses are not advanced.
              error_q <= 1'b1;
              state   <= FINISH;
            end else begin
              words_q <= words_q - LEN_WIDTH'(1);
              src_q   <= src_q + ADDR_WIDTH'(BPW);
              dst_q   <= dst_q + ADDR_WIDTH'(BPW);
              if (words_q == LEN_WIDTH'(1)) begin
                state <= FINISH;
              end else begin
                state      <= RD_REQ;
                rd_valid_q <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          irq_q  <= irq_en_q;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign irq          = irq_q;
  assign error        = error_q;
  assign dbg_state    = state;
  assign mem.rd_addr  = src_q;
  assign mem.rd_valid = rd_valid_q;
  assign mem.wr_addr  = dst_q;
  assign mem.wr_data  = data_q;
  assign mem.wr_valid = wr_valid_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_copy_engine
//   Directed bench for dma_copy_engine. A memory responder on the falling
//   edge answers the read/write channels (optional per-beat stall, optional
//   read error on a chosen word) and scores every accepted write against
//   the expected queues. Scenario tasks run in sequence and check status,
//   timing and beat counts inline.
// -----------------------------------------------------------------------------
module tb_dma_copy_engine;

  logic        clk;
  logic        ARESET;
  logic        start;
  logic        irq_enable;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] length;
  logic        busy;
  logic        done;
  logic        irq;
  logic        error;
  logic [2:0]  dbg_state;

  dma_copy_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  dma_copy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(32)) dut (
    .ACLK       (clk),
    .ARESET     (ARESET),
    .start      (start),
    .irq_enable (irq_enable),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .irq        (irq),
    .error      (error),
    .dbg_state  (dbg_state),
    .mem        (mem)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] got_rd_q[$];
  int          wr_beats;
  int          rd_beats;
  int          rd_valid_seen;
  int          stab_err;
  int          irq_cnt;
  int          rd_stall_cfg;
  int          wr_stall_cfg;
  int          err_rd_word;
  int          busy_c1;
  logic        done_irq;

  // Memory responder state
  int          rd_stall_n;
  int          wr_stall_n;
  logic        rd_pend;
  logic [31:0] rd_pend_addr;
  int          rd_pend_idx;
  logic        wr_pend;
  logic        rd_hold;
  logic [31:0] rd_hold_addr;
  logic        wr_hold;
  logic [31:0] wr_hold_addr;
  logic [31:0] wr_hold_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_reset();
    exp_q.delete();
    exp_addr_q.delete();
    got_rd_q.delete();
    wr_beats      = 0;
    rd_beats      = 0;
    rd_valid_seen = 0;
    stab_err      = 0;
    rd_stall_n    = 0;
    wr_stall_n    = 0;
    rd_pend       = 1'b0;
    wr_pend       = 1'b0;
    rd_hold       = 1'b0;
    wr_hold       = 1'b0;
  endtask

  // Responder: decides inputs at the falling edge for the next rising edge.
  initial begin
    mem.rd_ready  = 1'b0;
    mem.rd_dvalid = 1'b0;
    mem.rd_data   = '0;
    mem.rd_resp   = 2'b00;
    mem.wr_ready  = 1'b0;
    mem.wr_bvalid = 1'b0;
    mem.wr_resp   = 2'b00;
    forever begin
      @(negedge clk);
      mem.rd_dvalid = 1'b0;
      mem.rd_resp   = 2'b00;
      mem.wr_bvalid = 1'b0;
      mem.wr_resp   = 2'b00;
      if (irq === 1'b1) irq_cnt++;
      if (rd_pend) begin
        mem.rd_dvalid = 1'b1;
        mem.rd_data   = mem_word(rd_pend_addr);
        if (rd_pend_idx == err_rd_word) mem.rd_resp = 2'b10;
        rd_pend = 1'b0;
      end
      if (wr_pend) begin
        mem.wr_bvalid = 1'b1;
        wr_pend = 1'b0;
      end
      mem.rd_ready = 1'b0;
      if (mem.rd_valid === 1'b1) begin
        rd_valid_seen++;
        if (rd_hold && mem.rd_addr !== rd_hold_addr) stab_err++;
        rd_hold      = 1'b1;
        rd_hold_addr = mem.rd_addr;
        if (rd_stall_n < rd_stall_cfg) begin
          rd_stall_n++;
        end else begin
          mem.rd_ready = 1'b1;
          rd_stall_n   = 0;
          rd_pend      = 1'b1;
          rd_pend_addr = mem.rd_addr;
          rd_pend_idx  = rd_beats;
          got_rd_q.push_back(mem.rd_addr);
          rd_beats++;
          rd_hold = 1'b0;
        end
      end
      mem.wr_ready = 1'b0;
      if (mem.wr_valid === 1'b1) begin
        if (wr_hold && (mem.wr_addr !== wr_hold_addr || mem.wr_data !== wr_hold_data)) stab_err++;
        wr_hold      = 1'b1;
        wr_hold_addr = mem.wr_addr;
        wr_hold_data = mem.wr_data;
        if (wr_stall_n < wr_stall_cfg) begin
          wr_stall_n++;
        end else begin
          mem.wr_ready = 1'b1;
          wr_stall_n   = 0;
          wr_pend      = 1'b1;
          wr_hold      = 1'b0;
          wr_beats++;
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_extra: unexpected write addr=%h data=%h", mem.wr_addr, mem.wr_data);
          end else begin
            logic [31:0] ea;
            logic [31:0] ed;
            ea = exp_addr_q.pop_front();
            ed = exp_q.pop_front();
            if (mem.wr_addr !== ea || mem.wr_data !== ed) begin
              fails++;
              $display("FAIL wr_beat: got addr=%h data=%h, expected addr=%h data=%h",
                       mem.wr_addr, mem.wr_data, ea, ed);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Loads the expected writes (first nw words; nw<0 = all) and pulses start.
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic ie, input int nw);
    int w;
    mem_reset();
    w = int'(l >> 2);
    if (nw >= 0 && nw < w) w = nw;
    for (int i = 0; i < w; i++) begin
      exp_addr_q.push_back(d + 32'(4 * i));
      exp_q.push_back(mem_word(s + 32'(4 * i)));
    end
    src_addr   = s;
    dst_addr   = d;
    length     = l;
    irq_enable = ie;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    busy_c1    = int'(busy);
  endtask

  // Runs a copy to completion; cyc is the cycle index (start cycle = 0) in
  // which done is first seen. extra_at pulses a stray start in that cycle.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input logic ie, input int nw, input int extra_at, output int cyc);
    launch(s, d, l, ie, nw);
    cyc = 1;
    while (done !== 1'b1 && cyc < 500) begin
      if (cyc == extra_at) begin
        start    = 1'b1;
        src_addr = 32'h0000_0800;
        dst_addr = 32'h0000_0900;
        length   = 32'd4;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start    = 1'b0;
    done_irq = irq;
    if (done !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL timeout: done not seen within %0d cycles", cyc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, irq, error, mem.rd_valid, mem.wr_valid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, irq, error, mem.rd_valid, mem.wr_valid});
    end
    checks++;
    if (mem.rd_addr !== 32'h0 || mem.wr_addr !== 32'h0 || mem.wr_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_bus: rd_addr=%h wr_addr=%h wr_data=%h expected 0",
               mem.rd_addr, mem.wr_addr, mem.wr_data);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    int irq0;
    irq0 = irq_cnt;
    run_copy(32'h100, 32'h200, 32'd16, 1'b1, -1, 0, cyc);
    checks++;
    if (busy_c1 != 1) begin
      fails++;
      $display("FAIL basic_busy: busy=%0d in cycle 1, expected 1", busy_c1);
    end
    checks++;
    if (cyc != 18) begin
      fails++;
      $display("FAIL basic_latency: done at cycle %0d, expected 18", cyc);
    end
    checks++;
    if (wr_beats != 4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_beats: writes=%0d left=%0d, expected 4 and 0", wr_beats, exp_q.size());
    end
    tick();
    checks++;
    if (done_irq !== 1'b1 || irq_cnt - irq0 != 1 || irq !== 1'b0) begin
      fails++;
      $display("FAIL basic_irq: irq_at_done=%b pulses=%0d, expected 1 and 1", done_irq, irq_cnt - irq0);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL basic_status: busy=%b done=%b error=%b expected 0 1 0", busy, done, error);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    rd_stall_cfg = 5;
    wr_stall_cfg = 5;
    run_copy(32'h300, 32'h400, 32'd12, 1'b0, -1, 0, cyc);
    rd_stall_cfg = 0;
    wr_stall_cfg = 0;
    checks++;
    if (cyc != 44) begin
      fails++;
      $display("FAIL bp_latency: done at cycle %0d, expected 44", cyc);
    end
    checks++;
    if (stab_err != 0) begin
      fails++;
      $display("FAIL bp_stable: %0d changes while valid, expected 0", stab_err);
    end
    checks++;
    if (rd_beats != 3 || wr_beats != 3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_beats: reads=%0d writes=%0d left=%0d, expected 3 3 0",
               rd_beats, wr_beats, exp_q.size());
    end
    tick();
  endtask

  task automatic test_edge_cases();
    int cyc;
    // Zero length, with a stray start in the FINISH cycle.
    run_copy(32'h100, 32'h200, 32'd0, 1'b0, -1, 1, cyc);
    checks++;
    if (cyc != 2) begin
      fails++;
      $display("FAIL len0_latency: done at cycle %0d, expected 2", cyc);
    end
    tick();
    tick();
    checks++;
    if (rd_valid_seen != 0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL len0_idle: rd_valid_cycles=%0d busy=%b state=%0d, expected 0 0 0",
               rd_valid_seen, busy, dbg_state);
    end
    // Length 7 copies one word.
    run_copy(32'h140, 32'h240, 32'd7, 1'b0, -1, 0, cyc);
    checks++;
    if (cyc != 6 || wr_beats != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL len7: cycle=%0d writes=%0d, expected 6 and 1", cyc, wr_beats);
    end
    tick();
    // Source address wrap.
    run_copy(32'hFFFF_FFFC, 32'h500, 32'd8, 1'b0, -1, 0, cyc);
    checks++;
    if (got_rd_q.size() != 2) begin
      fails++;
      $display("FAIL wrap_reads: %0d reads, expected 2", got_rd_q.size());
    end else if (got_rd_q[1] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_addr: second rd_addr=%h, expected 00000000", got_rd_q[1]);
    end
    checks++;
    if (wr_beats != 2 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_beats: writes=%0d, expected 2", wr_beats);
    end
    tick();
  endtask

  task automatic test_start_busy_and_abort();
    int cyc;
    int irq0;
    run_copy(32'h600, 32'h700, 32'd16, 1'b1, -1, 6, cyc);
    checks++;
    if (cyc != 18 || wr_beats != 4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL busy_start: cycle=%0d writes=%0d, expected 18 and 4", cyc, wr_beats);
    end
    tick();
    irq0 = irq_cnt;
    launch(32'hC00, 32'hD00, 32'd16, 1'b1, -1);
    repeat (4) tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0 || mem.rd_valid !== 1'b0 ||
        mem.wr_valid !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b state=%0d rd_valid=%b wr_valid=%b done=%b, expected all 0",
               busy, dbg_state, mem.rd_valid, mem.wr_valid, done);
    end
    repeat (8) tick();
    checks++;
    if (irq_cnt != irq0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_irq: pulses=%0d done=%b, expected 0 and 0", irq_cnt - irq0, done);
    end
    mem_reset();
  endtask

  task automatic test_read_error();
    int cyc;
    int irq0;
    irq0 = irq_cnt;
    err_rd_word = 1;
`ifdef DMA_ERR_CHECK_EN
    run_copy(32'hA00, 32'hB00, 32'd16, 1'b1, 1, 0, cyc);
    checks++;
    if (cyc != 8 || wr_beats != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL err_abort: cycle=%0d writes=%0d, expected 8 and 1", cyc, wr_beats);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b1) begin
      fails++;
      $display("FAIL err_flags: error=%b done=%b, expected 1 1", error, done);
    end
`else
    run_copy(32'hA00, 32'hB00, 32'd16, 1'b1, -1, 0, cyc);
    checks++;
    if (cyc != 18 || wr_beats != 4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL err_ignored: cycle=%0d writes=%0d, expected 18 and 4", cyc, wr_beats);
    end
    checks++;
    if (error !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL err_flags: error=%b done=%b, expected 0 1", error, done);
    end
`endif
    err_rd_word = -1;
    tick();
    checks++;
    if (irq_cnt - irq0 != 1) begin
      fails++;
      $display("FAIL err_irq: pulses=%0d, expected 1", irq_cnt - irq0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ARESET       = 1'b1;
    start        = 1'b0;
    irq_enable   = 1'b0;
    src_addr     = '0;
    dst_addr     = '0;
    length       = '0;
    irq_cnt      = 0;
    rd_stall_cfg = 0;
    wr_stall_cfg = 0;
    err_rd_word  = -1;
    busy_c1      = 0;
    done_irq     = 1'b0;
    mem_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_cases();
    test_start_busy_and_abort();
    test_read_error();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
